// File: rtl/reset_run_sequencer_pkg.sv
// Shared types and defaults for the reset/run sequencer.
package optimsoc_reset_pkg;

    localparam int RUN_STATE_W       = 3;
    localparam int DEFAULT_SYS_HOLD  = 16;
    localparam int DEFAULT_CPU_DELAY = 8;
    localparam int DEFAULT_CPU_HOLD  = 8;

    // Encodings are visible on run_state, so they are fixed explicitly.
    typedef enum logic [RUN_STATE_W-1:0] {
        SYS_RST  = 3'd0,
        CPU_WAIT = 3'd1,
        RUN      = 3'd2,
        CPU_RST  = 3'd3,
        DONE     = 3'd4
    } run_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_run_sequencer_term_collector.sv
// Sticky per-core termination record with all-ones detection.
module term_collector #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [NUM_CORES-1:0] i_term,
    output logic [NUM_CORES-1:0] o_seen,
    output logic                 o_all,
    output logic                 o_all_now
);

    logic [NUM_CORES-1:0] r_seen;
    logic [NUM_CORES-1:0] w_seen_nxt;
    logic                 r_all;

    // Clear has priority; otherwise flags accumulate only while enabled.
    always_comb begin
        w_seen_nxt = r_seen;
        if (i_clear) begin
            w_seen_nxt = '0;
        end else if (i_enable) begin
            w_seen_nxt = r_seen | i_term;
        end
    end

    // Register the sticky vector and its all-ones summary together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen <= '0;
            r_all  <= 1'b0;
        end else begin
            r_seen <= w_seen_nxt;
            r_all  <= &w_seen_nxt;
        end
    end

    // Includes this cycle's flags so the FSM can leave RUN on the completing edge.
    assign o_all_now = &(r_seen | i_term);
    assign o_seen    = r_seen;
    assign o_all     = r_all;

endmodule

// File: rtl/reset_run_sequencer.sv
// Sequences system reset, CPU reset and CPU stall for all compute tiles.
module reset_run_sequencer
    import optimsoc_reset_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int SYS_HOLD  = DEFAULT_SYS_HOLD,
    parameter int CPU_DELAY = DEFAULT_CPU_DELAY,
    parameter int CPU_HOLD  = DEFAULT_CPU_HOLD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dbg_sys_rst_req,
    input  logic                   dbg_cpu_rst_req,
    input  logic                   dbg_stall,
    input  logic [NUM_CORES-1:0]   termination,
    output logic                   rst_sys,
    output logic                   rst_cpu,
    output logic                   cpu_stall,
    output logic                   all_terminated,
    output logic [NUM_CORES-1:0]   term_seen,
    output logic [RUN_STATE_W-1:0] run_state
);

    localparam int CNT_MAX = max3(SYS_HOLD, CPU_DELAY, CPU_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SYS_LAST   = CNT_W'(SYS_HOLD - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CPU_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    run_state_t       r_state;
    run_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_clr;
    logic             w_counting;
    logic             r_rst_sys;
    logic             r_rst_cpu;
    logic             r_stall;
    logic             w_rst_sys_d;
    logic             w_rst_cpu_d;
    logic             w_stall_d;
    logic             w_clear;
    logic             w_enable;
    logic             w_all_now;

    term_collector #(
        .NUM_CORES (NUM_CORES)
    ) u_term (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .i_term    (termination),
        .o_seen    (term_seen),
        .o_all     (all_terminated),
        .o_all_now (w_all_now)
    );

    // State, phase counter and decoded output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= SYS_RST;
            r_cnt     <= '0;
            r_rst_sys <= 1'b1;
            r_rst_cpu <= 1'b1;
            r_stall   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rst_sys <= w_rst_sys_d;
            r_rst_cpu <= w_rst_cpu_d;
            r_stall   <= w_stall_d;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // Timed phase progression, then debug requests override (sys beats cpu).
    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        case (r_state)
            SYS_RST:  if (r_cnt == SYS_LAST)   w_next = CPU_WAIT;
            CPU_WAIT: if (r_cnt == DELAY_LAST) w_next = RUN;
            RUN:      if (w_all_now)           w_next = DONE;
            CPU_RST:  if (r_cnt == HOLD_LAST)  w_next = CPU_WAIT;
            DONE:     w_next = DONE;
            default:  w_next = SYS_RST;
        endcase
        if (dbg_sys_rst_req) begin
            // A restart of SYS_RST keeps the state but must still rewind the counter.
            w_next    = SYS_RST;
            w_cnt_clr = 1'b1;
        end else if (dbg_cpu_rst_req && (r_state inside {RUN, CPU_WAIT, DONE})) begin
            w_next = CPU_RST;
        end
        if (w_next != r_state) begin
            w_cnt_clr = 1'b1;
        end
    end

    // Output values for the coming state; registered above.
    always_comb begin
        w_counting  = (r_state inside {SYS_RST, CPU_WAIT, CPU_RST});
        w_rst_sys_d = (w_next == SYS_RST);
        w_rst_cpu_d = (w_next inside {SYS_RST, CPU_WAIT, CPU_RST});
        w_stall_d   = (w_next == DONE) || ((w_next == RUN) && dbg_stall);
        w_clear     = (w_next == SYS_RST) || (w_next == CPU_RST);
        w_enable    = (r_state == RUN);
    end

    assign rst_sys   = r_rst_sys;
    assign rst_cpu   = r_rst_cpu;
    assign cpu_stall = r_stall;
    assign run_state = r_state;

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Bench for reset_run_sequencer: directed vector table plus randomized run against a reference model.
module tb_reset_run_sequencer;

    localparam int NC = 4;
    localparam int SH = 16;
    localparam int CD = 8;
    localparam int CH = 8;

    localparam int P_SYS  = 0;
    localparam int P_WAIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_CRST = 3;
    localparam int P_DONE = 4;

    logic          clk;
    logic          rst_n;
    logic          dbg_sys_rst_req;
    logic          dbg_cpu_rst_req;
    logic          dbg_stall;
    logic [NC-1:0] termination;
    logic          rst_sys;
    logic          rst_cpu;
    logic          cpu_stall;
    logic          all_terminated;
    logic [NC-1:0] term_seen;
    logic [2:0]    run_state;

    int n_checks = 0;
    int n_errors = 0;

    reset_run_sequencer #(
        .NUM_CORES (NC),
        .SYS_HOLD  (SH),
        .CPU_DELAY (CD),
        .CPU_HOLD  (CH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dbg_sys_rst_req (dbg_sys_rst_req),
        .dbg_cpu_rst_req (dbg_cpu_rst_req),
        .dbg_stall       (dbg_stall),
        .termination     (termination),
        .rst_sys         (rst_sys),
        .rst_cpu         (rst_cpu),
        .cpu_stall       (cpu_stall),
        .all_terminated  (all_terminated),
        .term_seen       (term_seen),
        .run_state       (run_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus cycles-remaining timer and a per-core "seen" table.
    int m_phase;
    int m_left;
    bit m_seen [NC];
    bit m_all;
    bit m_stall;

    function automatic logic [NC-1:0] m_seen_vec();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = m_seen[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_seen[i] = 1'b0;
    endtask

    task automatic model_step();
        int cnt;
        if (!rst_n) begin
            m_phase = P_SYS; m_left = SH; model_clear();
        end else if (dbg_sys_rst_req) begin
            m_phase = P_SYS; m_left = SH; model_clear();
        end else if (dbg_cpu_rst_req &&
                     (m_phase == P_RUN || m_phase == P_WAIT || m_phase == P_DONE)) begin
            m_phase = P_CRST; m_left = CH; model_clear();
        end else begin
            case (m_phase)
                P_SYS: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_WAIT; m_left = CD; end
                end
                P_WAIT: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_RUN;
                end
                P_CRST: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_WAIT; m_left = CD; end
                end
                P_RUN: begin
                    cnt = 0;
                    for (int i = 0; i < NC; i++) begin
                        if (termination[i]) m_seen[i] = 1'b1;
                        if (m_seen[i]) cnt++;
                    end
                    if (cnt == NC) m_phase = P_DONE;
                end
                default: ;
            endcase
        end
        m_all = 1'b1;
        for (int i = 0; i < NC; i++) if (!m_seen[i]) m_all = 1'b0;
        m_stall = rst_n && ((m_phase == P_DONE) || (m_phase == P_RUN && dbg_stall));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.run_state", 32'(run_state), 32'(m_phase));
        chk("model.rst_sys", 32'(rst_sys), 32'(m_phase == P_SYS));
        chk("model.rst_cpu", 32'(rst_cpu),
            32'(m_phase == P_SYS || m_phase == P_WAIT || m_phase == P_CRST));
        chk("model.cpu_stall", 32'(cpu_stall), 32'(m_stall));
        chk("model.all_terminated", 32'(all_terminated), 32'(m_all));
        chk("model.term_seen", 32'(term_seen), 32'(m_seen_vec()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        bit            r;
        bit            s;
        bit            c;
        bit            st;
        logic [NC-1:0] t;
        int            n;
        logic [2:0]    e_state;
        bit            e_sys;
        bit            e_cpu;
        bit            e_stall;
        bit            e_all;
        logic [NC-1:0] e_seen;
    } row_t;

    row_t rows[$];

    task automatic add(input bit r, input bit s, input bit c, input bit st, input logic [NC-1:0] t,
                       input int n, input logic [2:0] es, input bit ers, input bit erc,
                       input bit est, input bit ea, input logic [NC-1:0] eseen);
        row_t x;
        x.r = r; x.s = s; x.c = c; x.st = st; x.t = t; x.n = n;
        x.e_state = es; x.e_sys = ers; x.e_cpu = erc; x.e_stall = est; x.e_all = ea; x.e_seen = eseen;
        rows.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0; dbg_sys_rst_req = 1'b0; dbg_cpu_rst_req = 1'b0;
        dbg_stall = 1'b0; termination = '0;
        m_phase = P_SYS; m_left = SH; m_all = 1'b0; m_stall = 1'b0; model_clear();

        //   rst sys cpu stl term    n  state sys cpu stl all seen
        add(0, 0, 0, 0, 4'h0,  3, 3'd0, 1, 1, 0, 0, 4'h0); // reset values
        add(1, 0, 0, 0, 4'h0, 15, 3'd0, 1, 1, 0, 0, 4'h0); // rst_sys still held
        add(1, 0, 0, 0, 4'h0,  1, 3'd1, 0, 1, 0, 0, 4'h0); // 16th cycle: rst_sys drops
        add(1, 0, 0, 0, 4'h0,  7, 3'd1, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd2, 0, 0, 0, 0, 4'h0); // rst_cpu drops 8 later
        add(1, 0, 0, 0, 4'h1,  1, 3'd2, 0, 0, 0, 0, 4'h1);
        add(1, 0, 0, 0, 4'h0,  1, 3'd2, 0, 0, 0, 0, 4'h1);
        add(1, 0, 0, 0, 4'h4,  1, 3'd2, 0, 0, 0, 0, 4'h5);
        add(1, 0, 0, 0, 4'hA,  1, 3'd4, 0, 0, 1, 1, 4'hF); // all terminated -> DONE
        add(1, 0, 0, 0, 4'h0,  3, 3'd4, 0, 0, 1, 1, 4'hF);
        add(1, 0, 1, 0, 4'h0,  1, 3'd3, 0, 1, 0, 0, 4'h0); // cpu reset from DONE
        add(1, 0, 0, 0, 4'h0,  7, 3'd3, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd1, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'hF,  7, 3'd1, 0, 1, 0, 0, 4'h0); // termination ignored in CPU_WAIT
        add(1, 0, 0, 0, 4'hF,  1, 3'd2, 0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd2, 0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 1, 4'h0,  1, 3'd2, 0, 0, 1, 0, 4'h0); // stall after one cycle
        add(1, 0, 0, 1, 4'h0,  4, 3'd2, 0, 0, 1, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd2, 0, 0, 0, 0, 4'h0);
        add(1, 0, 1, 0, 4'h0,  1, 3'd3, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  3, 3'd3, 0, 1, 0, 0, 4'h0); // counter at 3
        add(1, 1, 1, 0, 4'h0,  1, 3'd0, 1, 1, 0, 0, 4'h0); // sys beats cpu
        add(1, 0, 0, 0, 4'h0, 15, 3'd0, 1, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd1, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  7, 3'd1, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd2, 0, 0, 0, 0, 4'h0);
        add(1, 1, 0, 0, 4'h0,  1, 3'd0, 1, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  5, 3'd0, 1, 1, 0, 0, 4'h0);
        add(1, 1, 0, 0, 4'h0,  1, 3'd0, 1, 1, 0, 0, 4'h0); // restart SYS_RST
        add(1, 0, 0, 0, 4'h0, 15, 3'd0, 1, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd1, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  8, 3'd2, 0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'hF,  1, 3'd4, 0, 0, 1, 1, 4'hF);
        add(0, 0, 0, 0, 4'h0,  1, 3'd0, 1, 1, 0, 0, 4'h0); // mid-run rst_n
        add(1, 0, 0, 0, 4'h0,  4, 3'd0, 1, 1, 0, 0, 4'h0);
        add(1, 0, 1, 0, 4'h0,  1, 3'd0, 1, 1, 0, 0, 4'h0); // cpu req ignored in SYS_RST
        add(1, 0, 0, 0, 4'h0, 10, 3'd0, 1, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  1, 3'd1, 0, 1, 0, 0, 4'h0);
        add(1, 0, 0, 0, 4'h0,  8, 3'd2, 0, 0, 0, 0, 4'h0);

        @(negedge clk);
        for (int k = 0; k < rows.size(); k++) begin
            rst_n           = rows[k].r;
            dbg_sys_rst_req = rows[k].s;
            dbg_cpu_rst_req = rows[k].c;
            dbg_stall       = rows[k].st;
            termination     = rows[k].t;
            for (int j = 0; j < rows[k].n; j++) begin
                tick();
                if (j == 0) begin
                    dbg_sys_rst_req = 1'b0;
                    dbg_cpu_rst_req = 1'b0;
                end
            end
            chk($sformatf("row%0d.run_state", k), 32'(run_state), 32'(rows[k].e_state));
            chk($sformatf("row%0d.rst_sys", k), 32'(rst_sys), 32'(rows[k].e_sys));
            chk($sformatf("row%0d.rst_cpu", k), 32'(rst_cpu), 32'(rows[k].e_cpu));
            chk($sformatf("row%0d.cpu_stall", k), 32'(cpu_stall), 32'(rows[k].e_stall));
            chk($sformatf("row%0d.all_terminated", k), 32'(all_terminated), 32'(rows[k].e_all));
            chk($sformatf("row%0d.term_seen", k), 32'(term_seen), 32'(rows[k].e_seen));
        end

        // Randomized traffic checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_n           = ($urandom_range(0, 299) != 0);
            dbg_sys_rst_req = ($urandom_range(0, 149) == 0);
            dbg_cpu_rst_req = ($urandom_range(0, 59) == 0);
            dbg_stall       = ($urandom_range(0, 3) == 0);
            termination     = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
